// File: rtl/matrix1_1_switchbox.sv
// ---------------------------------------------------------------------------
// matrix1_1_switchbox
//
// Purpose:
//   Configurable routing switchbox. Every routing pin on the four sides can be
//   left as an input (high-Z) or driven from one pin on another side, either
//   combinationally or through a per-pin flop. The routing pattern lives in a
//   serial shift-register configuration store, three bits per pin.
//
// Parameters:
//   NV  number of vertical tracks   (width of wtop / wbottom)
//   NH  number of horizontal tracks (width of wleft / wright), NH <= NV
//
// Ports:
//   clk      in   single clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   cfg_en   in   configuration shift enable; all pins float while high
//   cfg_in   in   serial configuration data, enters at the top of the store
//   cfg_out  out  serial configuration data, bit 0 of the store
//   wtop     io   top routing pins        (pin numbers 0 .. NV-1)
//   wbottom  io   bottom routing pins     (pin numbers NV .. 2NV-1)
//   wleft    io   left routing pins       (pin numbers 2NV .. 2NV+NH-1)
//   wright   io   right routing pins      (pin numbers 2NV+NH .. 2NV+2NH-1)
//
// Per-pin field F = cfg[3p+2:3p]:
//   F[1:0] 00 input only, 01 opposite side same index,
//          10 wleft[i mod NH] / wtop[j], 11 wright[i mod NH] / wbottom[j]
//   F[2]   0 combinational path, 1 registered path
// ---------------------------------------------------------------------------
module matrix1_1_switchbox #(
  parameter int NV = 5,
  parameter int NH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_en,
  input  logic          cfg_in,
  output logic          cfg_out,
  inout  wire  [NV-1:0] wtop,
  inout  wire  [NV-1:0] wbottom,
  inout  wire  [NH-1:0] wleft,
  inout  wire  [NH-1:0] wright
);

  localparam int NP      = 2*NV + 2*NH;  // total routing pins
  localparam int L       = 3*NP;         // configuration store length
  localparam int P_BOT   = NV;           // first bottom pin number
  localparam int P_LEFT  = 2*NV;         // first left pin number
  localparam int P_RIGHT = 2*NV + NH;    // first right pin number

  // Pin number that feeds pin p for a given non-zero source select.
  // Evaluated at elaboration only, so every mux leg is a fixed wire.
  function automatic int src_index(input int p, input int sel);
    int idx;
    int i;
    idx = 0;
    if (p < P_LEFT) begin
      // vertical pin, index i along its side
      i = (p < P_BOT) ? p : p - P_BOT;
      case (sel)
        1:       idx = (p < P_BOT) ? P_BOT + i : i;
        2:       idx = P_LEFT  + (i % NH);
        3:       idx = P_RIGHT + (i % NH);
        default: idx = 0;
      endcase
    end else begin
      // horizontal pin, index i along its side
      i = (p < P_RIGHT) ? p - P_LEFT : p - P_RIGHT;
      case (sel)
        1:       idx = (p < P_RIGHT) ? P_RIGHT + i : P_LEFT + i;
        2:       idx = i;
        3:       idx = P_BOT + i;
        default: idx = 0;
      endcase
    end
    return idx;
  endfunction

  logic [L-1:0]  r_cfg;      // configuration store
  logic [NP-1:0] r_pin_q;    // per-pin registered path

  logic [NP-1:0] w_pin;      // resolved value seen on every pin
  logic [NP-1:0] w_avail;    // pin value offered to others as a source
  logic [NP-1:0] w_src;      // selected source value per pin
  logic [NP-1:0] w_oe;       // pin output enable
  logic [NP-1:0] w_drv;      // value driven when enabled

  assign w_pin   = {wright, wleft, wbottom, wtop};
  assign cfg_out = r_cfg[0];

  // Configuration store: serial shift towards bit 0 while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg <= '0;
    end else if (cfg_en) begin
      r_cfg <= {cfg_in, r_cfg[L-1:1]};
    end
  end

  // Registered path: samples the selected source every edge outside of
  // configuration shifting, and freezes while the store is being rewritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pin_q <= '0;
    end else if (!cfg_en) begin
      r_pin_q <= w_src;
    end
  end

  for (genvar p = 0; p < NP; p++) begin : g_pin
    localparam int SRC_OPP = src_index(p, 1);
    localparam int SRC_A   = src_index(p, 2);
    localparam int SRC_B   = src_index(p, 3);

    logic [2:0] w_fld;
    assign w_fld = r_cfg[3*p +: 3];

    // Only a pin that is itself an input may act as a source. A driven pin
    // offers a constant 0, which rules out loops and multi-hop chains
    // through the box.
    assign w_avail[p] = (w_fld[1:0] == 2'b00) ? w_pin[p] : 1'b0;

    assign w_src[p] = (w_fld[1:0] == 2'b01) ? w_avail[SRC_OPP] :
                      (w_fld[1:0] == 2'b10) ? w_avail[SRC_A]   :
                      (w_fld[1:0] == 2'b11) ? w_avail[SRC_B]   : 1'b0;

    // Float everything while shifting so partial patterns never route.
    assign w_oe[p]  = ~cfg_en & (w_fld[1:0] != 2'b00);
    assign w_drv[p] = w_fld[2] ? r_pin_q[p] : w_src[p];
  end

  for (genvar i = 0; i < NV; i++) begin : g_vert_drv
    assign wtop[i]    = w_oe[i]         ? w_drv[i]         : 1'bz;
    assign wbottom[i] = w_oe[P_BOT + i] ? w_drv[P_BOT + i] : 1'bz;
  end

  for (genvar j = 0; j < NH; j++) begin : g_horz_drv
    assign wleft[j]  = w_oe[P_LEFT + j]  ? w_drv[P_LEFT + j]  : 1'bz;
    assign wright[j] = w_oe[P_RIGHT + j] ? w_drv[P_RIGHT + j] : 1'bz;
  end

endmodule

// File: tb/tb_matrix1_1_switchbox.sv
// ---------------------------------------------------------------------------
// tb_matrix1_1_switchbox
//
// Two copies of the switchbox see identical stimulus. The nets of one copy
// are pulled high, the other pulled low, so a pin that nobody drives reads 1
// on the first and 0 on the second; a driven pin reads the same on both.
// Each pin is therefore observed as a code: 0, 1, 2 (undriven), 3 (conflict).
// ---------------------------------------------------------------------------
module tb_matrix1_1_switchbox;

  localparam int NV = 5;
  localparam int NH = 4;
  localparam int NP = 2*NV + 2*NH;
  localparam int L  = 3*NP;
  localparam int ZC = 2;   // code for an undriven pin

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic cfg_en;
  logic cfg_in;
  logic cfg_out_up;
  logic cfg_out_dn;

  tri1 [NV-1:0] top_up;
  tri1 [NV-1:0] bot_up;
  tri1 [NH-1:0] left_up;
  tri1 [NH-1:0] right_up;
  tri0 [NV-1:0] top_dn;
  tri0 [NV-1:0] bot_dn;
  tri0 [NH-1:0] left_dn;
  tri0 [NH-1:0] right_dn;

  logic [NP-1:0] tb_en;
  logic [NP-1:0] tb_val;

  wire [NP-1:0] w_up = {right_up, left_up, bot_up, top_up};
  wire [NP-1:0] w_dn = {right_dn, left_dn, bot_dn, top_dn};

  for (genvar i = 0; i < NV; i++) begin : g_tb_v
    assign top_up[i] = tb_en[i]      ? tb_val[i]      : 1'bz;
    assign top_dn[i] = tb_en[i]      ? tb_val[i]      : 1'bz;
    assign bot_up[i] = tb_en[NV + i] ? tb_val[NV + i] : 1'bz;
    assign bot_dn[i] = tb_en[NV + i] ? tb_val[NV + i] : 1'bz;
  end
  for (genvar j = 0; j < NH; j++) begin : g_tb_h
    assign left_up[j]  = tb_en[2*NV + j]      ? tb_val[2*NV + j]      : 1'bz;
    assign left_dn[j]  = tb_en[2*NV + j]      ? tb_val[2*NV + j]      : 1'bz;
    assign right_up[j] = tb_en[2*NV + NH + j] ? tb_val[2*NV + NH + j] : 1'bz;
    assign right_dn[j] = tb_en[2*NV + NH + j] ? tb_val[2*NV + NH + j] : 1'bz;
  end

  matrix1_1_switchbox #(.NV(NV), .NH(NH)) u_up (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_in(cfg_in),
    .cfg_out(cfg_out_up),
    .wtop(top_up), .wbottom(bot_up), .wleft(left_up), .wright(right_up)
  );

  matrix1_1_switchbox #(.NV(NV), .NH(NH)) u_dn (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_in(cfg_in),
    .cfg_out(cfg_out_dn),
    .wtop(top_dn), .wbottom(bot_dn), .wleft(left_dn), .wright(right_dn)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int obs(input int p);
    logic u;
    logic d;
    u = w_up[p];
    d = w_dn[p];
    if (u === 1'b0 && d === 1'b0) return 0;
    if (u === 1'b1 && d === 1'b1) return 1;
    if (u === 1'b1 && d === 1'b0) return ZC;
    return 3;
  endfunction

  // ---------------- behavioural model ----------------
  logic [L-1:0] m_cfg = '0;
  int           m_q  [NP];
  int           m_nq [NP];

  function automatic int fsel(input int p);
    return int'({m_cfg[3*p+1], m_cfg[3*p]});
  endfunction

  // Which pin feeds pin p for source select s (1..3), from the routing rules.
  function automatic int src_pin(input int p, input int s);
    int side;   // 0 top, 1 bottom, 2 left, 3 right
    int idx;
    if (p < NV)              begin side = 0; idx = p;             end
    else if (p < 2*NV)       begin side = 1; idx = p - NV;        end
    else if (p < 2*NV + NH)  begin side = 2; idx = p - 2*NV;      end
    else                     begin side = 3; idx = p - 2*NV - NH; end
    if (s == 1) begin
      if (side == 0) return NV + idx;
      if (side == 1) return idx;
      if (side == 2) return 2*NV + NH + idx;
      return 2*NV + idx;
    end
    if (side < 2) return (s == 2) ? 2*NV + (idx % NH) : 2*NV + NH + (idx % NH);
    return (s == 2) ? idx : NV + idx;
  endfunction

  function automatic int ext(input int p);
    return tb_en[p] ? int'(tb_val[p]) : ZC;
  endfunction

  function automatic int avail(input int k);
    return (fsel(k) == 0) ? ext(k) : 0;
  endfunction

  function automatic int exp_pin(input int p);
    int s;
    s = fsel(p);
    if (cfg_en || s == 0) return ext(p);
    if (m_cfg[3*p+2]) return m_q[p];
    return avail(src_pin(p, s));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cfg = '0;
      for (int p = 0; p < NP; p++) m_q[p] = 0;
    end else if (cfg_en) begin
      m_cfg = {cfg_in, m_cfg[L-1:1]};
    end else begin
      for (int p = 0; p < NP; p++)
        m_nq[p] = (fsel(p) == 0) ? 0 : avail(src_pin(p, fsel(p)));
      for (int p = 0; p < NP; p++) m_q[p] = m_nq[p];
    end
  end

  // Every cycle: all pins and cfg_out against the model.
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++)
      chk($sformatf("model_pin%0d", p), obs(p), exp_pin(p));
    chk("model_cfg_out_up", int'(cfg_out_up), int'(m_cfg[0]));
    chk("model_cfg_out_dn", int'(cfg_out_dn), int'(m_cfg[0]));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [L-1:0] pat);
    cfg_en = 1'b1;
    for (int k = 0; k < L; k++) begin
      cfg_in = pat[k];
      tick();
      if (k == 10) chk("load_pins_float", obs(11), ZC);
    end
    cfg_en = 1'b0;
    cfg_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  logic [L-1:0] pat;
  logic [L-1:0] known;
  int           rpat [5];

  initial begin
    rst_n  = 1'b0;
    cfg_en = 1'b0;
    cfg_in = 1'b0;
    tb_en  = '0;
    tb_val = '0;
    repeat (3) tick();
    chk("rst_cfg_out", int'(cfg_out_up), 0);
    chk("rst_pin0_z", obs(0), ZC);
    chk("rst_pin17_z", obs(17), ZC);
    rst_n = 1'b1;
    tick();

    // Idle: external toggling of wright[1] routes nowhere.
    rpat = '{0, 1, 0, 0, 1};
    tb_en[15] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tb_val[15] = rpat[k][0];
      repeat (3) tick();
      chk("idle_wright1", obs(15), rpat[k]);
      chk("idle_wleft1_z", obs(11), ZC);
      chk("idle_wtop1_z", obs(1), ZC);
      chk("idle_cfg_out", int'(cfg_out_up), 0);
    end

    // wleft[1] <- wright[1] combinationally.
    pat = '0;
    pat[33] = 1'b1;
    load(pat);
    tb_val[15] = 1'b0; #1 chk("comb_opp_0", obs(11), 0);
    tb_val[15] = 1'b1; #1 chk("comb_opp_1", obs(11), 1);
    tb_val[15] = 1'b0; #1 chk("comb_opp_0b", obs(11), 0);
    chk("comb_opp_wleft0_z", obs(10), ZC);
    tick();

    // wtop[1] <- wright[1 mod 4] combinationally.
    pat = '0;
    pat[3] = 1'b1;
    pat[4] = 1'b1;
    load(pat);
    tb_val[15] = 1'b1; #1 chk("comb_top_1", obs(1), 1);
    tb_val[15] = 1'b0; #1 chk("comb_top_0", obs(1), 0);
    chk("comb_top_wleft1_z", obs(11), ZC);
    tick();

    // wleft[1] <- wright[1] through the flop: one-edge delay, starts at 0.
    pat = '0;
    pat[33] = 1'b1;
    pat[35] = 1'b1;
    load(pat);
    #1 chk("reg_first", obs(11), 0);
    tb_val[15] = 1'b1; #1 chk("reg_before_edge", obs(11), 0);
    tick();
    chk("reg_after_edge1", obs(11), 1);
    tb_val[15] = 1'b0; #1 chk("reg_hold", obs(11), 1);
    tick();
    chk("reg_after_edge0", obs(11), 0);
    tick();

    // Mutual opposite routing: both sides see a driven neighbour and drive 0.
    tb_en = '0;
    pat = '0;
    pat[33] = 1'b1;
    pat[45] = 1'b1;
    load(pat);
    tick();
    chk("mutual_wleft1", obs(11), 0);
    chk("mutual_wright1", obs(15), 0);
    chk("mutual_wtop1_z", obs(1), ZC);
    rst_n = 1'b0;
    #1 chk("rst_async_wleft1_z", obs(11), ZC);
    chk("rst_async_wright1_z", obs(15), ZC);
    chk("rst_async_cfg_out", int'(cfg_out_up), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset mid-shift discards the partial pattern.
    cfg_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cfg_in = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    #1 chk("midshift_rst_cfg_out", int'(cfg_out_up), 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < L; k++) begin
      chk("midshift_readback_zero", int'(cfg_out_up), 0);
      cfg_in = 1'b0;
      tick();
    end
    cfg_en = 1'b0;
    tick();

    // Shift a known pattern, then shift it out through cfg_out in order.
    known = 54'h0A5C3F0D96E71B;
    cfg_en = 1'b1;
    for (int k = 0; k < L; k++) begin
      cfg_in = known[k];
      tick();
      if (k % 9 == 4) chk("shift_pin0_z", obs(0), ZC);
    end
    for (int k = 0; k < L; k++) begin
      chk($sformatf("shift_out_bit%0d", k), int'(cfg_out_up), int'(known[k]));
      cfg_in = 1'b0;
      tick();
    end
    cfg_en = 1'b0;
    tick();
    chk("final_cfg_out", int'(cfg_out_up), 0);
    chk("final_pin9_z", obs(9), ZC);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
